// File: rtl/generic_bus_queued_manager_if.sv
// ---------------------------------------------------------------------------
// generic_bus_queued_manager_if
//   Bundles the device-side request/response signals and the GenericBus
//   signals of the queued manager.
//   master : view of the manager itself (drives dev responses and bus regs)
//   slave  : view of the surroundings (device requests, subordinate replies)
//   Device side : dev_wEn, dev_rEn, dev_addr, dev_wStrb, dev_wData  -> manager
//                 dev_ready, dev_count, dev_rValid, dev_wDone, dev_rData,
//                 dev_error, dev_dropped, dev_busy                   <- manager
//   Bus side    : bus_wEn, bus_rEn, bus_addr, bus_wStrb, bus_wData   <- manager
//                 bus_rData, bus_error, bus_busy                     -> manager
// ---------------------------------------------------------------------------
interface generic_bus_queued_manager_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              dev_wEn;
    logic              dev_rEn;
    logic [ADDR_W-1:0] dev_addr;
    logic [STRB_W-1:0] dev_wStrb;
    logic [DATA_W-1:0] dev_wData;
    logic              dev_ready;
    logic [CNT_W-1:0]  dev_count;
    logic              dev_rValid;
    logic              dev_wDone;
    logic [DATA_W-1:0] dev_rData;
    logic              dev_error;
    logic              dev_dropped;
    logic              dev_busy;

    logic              bus_wEn;
    logic              bus_rEn;
    logic [ADDR_W-1:0] bus_addr;
    logic [STRB_W-1:0] bus_wStrb;
    logic [DATA_W-1:0] bus_wData;
    logic [DATA_W-1:0] bus_rData;
    logic              bus_error;
    logic              bus_busy;

    modport master (
        input  dev_wEn, dev_rEn, dev_addr, dev_wStrb, dev_wData,
        input  bus_rData, bus_error, bus_busy,
        output dev_ready, dev_count, dev_rValid, dev_wDone, dev_rData,
        output dev_error, dev_dropped, dev_busy,
        output bus_wEn, bus_rEn, bus_addr, bus_wStrb, bus_wData
    );

    modport slave (
        output dev_wEn, dev_rEn, dev_addr, dev_wStrb, dev_wData,
        output bus_rData, bus_error, bus_busy,
        input  dev_ready, dev_count, dev_rValid, dev_wDone, dev_rData,
        input  dev_error, dev_dropped, dev_busy,
        input  bus_wEn, bus_rEn, bus_addr, bus_wStrb, bus_wData
    );
endinterface

// File: rtl/generic_bus_queued_manager.sv
// ---------------------------------------------------------------------------
// generic_bus_queued_manager
//   GenericBus manager for a single device. Device requests are posted into a
//   DEPTH-entry FIFO; the FIFO head is issued on the bus as soon as the
//   previous transfer completes, sustaining one transfer per cycle when the
//   subordinate never stalls. Each completion is reported back to the device
//   (dev_rValid / dev_wDone with dev_error). With FLUSH_ON_ERR set, a bus
//   error throws away every queued request plus any push in that same cycle.
//   clk    : clock, everything on posedge
//   nReset : asynchronous active-low reset
//   mgr    : device + bus signal bundle (master modport)
// ---------------------------------------------------------------------------
module generic_bus_queued_manager #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 4,
    parameter bit FLUSH_ON_ERR = 1'b1
) (
    input logic                         clk,
    input logic                         nReset,
    generic_bus_queued_manager_if.master mgr
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              wen;
        logic              ren;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t              mem [DEPTH];
    req_t              head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              ready_q;

    logic              bus_wen_q;
    logic              bus_ren_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [STRB_W-1:0] bus_strb_q;
    logic [DATA_W-1:0] bus_data_q;

    logic              rvalid_q;
    logic              wdone_q;
    logic              error_q;
    logic              dropped_q;
    logic [DATA_W-1:0] rdata_q;

    logic              active;
    logic              complete;
    logic              flush;
    logic              push_req;
    logic              push;
    logic              can_load;
    logic              pop;

    assign head = mem[rd_ptr];

    // Handshake decode. The bus registers may reload whenever nothing is in
    // flight or the current transfer is completing; a flush overrides both the
    // pop and any push so the bus goes idle with an empty queue.
    always_comb begin
        active     = bus_wen_q || bus_ren_q;
        complete   = active && !mgr.bus_busy;
        flush      = FLUSH_ON_ERR && complete && mgr.bus_error;
        push_req   = (mgr.dev_wEn || mgr.dev_rEn) && ready_q;
        push       = push_req && !flush;
        can_load   = !active || !mgr.bus_busy;
        pop        = can_load && (count != '0) && !flush;
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{wen:  mgr.dev_wEn,
                             ren:  mgr.dev_rEn,
                             addr: mgr.dev_addr,
                             strb: mgr.dev_wStrb,
                             data: mgr.dev_wData};
        end
    end

    // Pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count   <= count_next;
            ready_q <= (count_next != CNT_W'(DEPTH));
        end
    end

    // Bus request registers. With nothing left to issue the enables drop but
    // address/strobe/data keep their last values.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            bus_wen_q  <= 1'b0;
            bus_ren_q  <= 1'b0;
            bus_addr_q <= '0;
            bus_strb_q <= '0;
            bus_data_q <= '0;
        end else if (can_load) begin
            if (pop) begin
                bus_wen_q  <= head.wen;
                bus_ren_q  <= head.ren;
                bus_addr_q <= head.addr;
                bus_strb_q <= head.strb;
                bus_data_q <= head.data;
            end else begin
                bus_wen_q <= 1'b0;
                bus_ren_q <= 1'b0;
            end
        end
    end

    // Device responses, one cycle after the completing edge. Read data is
    // held until the next read completes.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rvalid_q  <= 1'b0;
            wdone_q   <= 1'b0;
            error_q   <= 1'b0;
            dropped_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rvalid_q  <= complete && bus_ren_q;
            wdone_q   <= complete && bus_wen_q;
            error_q   <= complete && mgr.bus_error;
            dropped_q <= flush && ((count != '0) || push_req);
            if (complete && bus_ren_q) begin
                rdata_q <= mgr.bus_rData;
            end
        end
    end

    assign mgr.dev_ready   = ready_q;
    assign mgr.dev_count   = count;
    assign mgr.dev_rValid  = rvalid_q;
    assign mgr.dev_wDone   = wdone_q;
    assign mgr.dev_rData   = rdata_q;
    assign mgr.dev_error   = error_q;
    assign mgr.dev_dropped = dropped_q;
    assign mgr.dev_busy    = (count != '0) || active;
    assign mgr.bus_wEn     = bus_wen_q;
    assign mgr.bus_rEn     = bus_ren_q;
    assign mgr.bus_addr    = bus_addr_q;
    assign mgr.bus_wStrb   = bus_strb_q;
    assign mgr.bus_wData   = bus_data_q;
endmodule
